// File: rtl/digit_serial_sub_pkg.sv
// Shared constants and helpers for the digit-serial subtractor.
//   state_t     : FSM state encoding (IDLE, RUN, DONE)
//   digit_count : number of D-bit digits in an N-bit operand
//   cnt_width   : digit counter width, never less than 1
package digit_serial_sub_pkg;

   localparam int unsigned DSS_N = 16;
   localparam int unsigned DSS_D = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned digit_count(input int unsigned n, input int unsigned d);
      return n / d;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n, input int unsigned d);
      int unsigned w;
      w = $clog2(n / d);
      return (w < 1) ? 1 : w;
   endfunction

   localparam int unsigned DSS_DIGITS = digit_count(DSS_N, DSS_D);
   localparam int unsigned DSS_CNT_W  = cnt_width(DSS_N, DSS_D);

endpackage

// File: rtl/digit_serial_sub_fs.sv
// 1-bit full subtractor: d = a - b - bin, bout = borrow out.
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   d, bout   : difference bit, borrow out
module digit_serial_sub_fs (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   // Borrow when b exceeds a, or when they match and a borrow arrives.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/digit_serial_sub.sv
// Multi-cycle subtractor: Diff = A - B - Bi, D bits per clock with a
// registered borrow between digits. start/busy/done handshake; the result
// is held until the next operation completes.
//   clk, rst       : clock, asynchronous active-high reset
//   start          : request, accepted when not busy (IDLE or DONE)
//   A, B, Bi       : operands and borrow-in, captured on accepted start
//   busy           : high while digits are being processed
//   done           : one-cycle pulse, result valid
//   Diff, Bo, ovf  : difference, borrow-out, two's-complement overflow
module digit_serial_sub
   import digit_serial_sub_pkg::*;
#(
   parameter int unsigned N = DSS_N,
   parameter int unsigned D = DSS_D
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Bi,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] Diff,
   output logic         Bo,
   output logic         ovf
);

   localparam int unsigned DIGITS = digit_count(N, D);
   localparam int unsigned CNT_W  = cnt_width(N, D);

   // Reject widths that do not split into whole digits.
   generate
      if ((D == 0) || ((N % D) != 0)) begin : g_bad_width
         $error("digit_serial_sub: N must be a non-zero multiple of D");
      end
   endgenerate

   state_t             state_q;
   state_t             state_d;
   logic [N-1:0]       a_sr;
   logic [N-1:0]       b_sr;
   logic [N-1:0]       res_sr;
   logic               borrow_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               a_msb;
   logic               b_msb;

   logic               cnt_last_c;
   logic               load_c;
   logic               step_c;
   logic               finish_c;
   logic               busy_nxt_c;
   logic               done_nxt_c;

   logic [D:0]         chain_c;
   logic [D-1:0]       digit_c;
   logic [N-1:0]       res_next_c;

   assign cnt_last_c = (cnt_q == CNT_W'(DIGITS - 1));

   // Per-cycle digit subtractor: D full subtractors seeded by the registered borrow.
   assign chain_c[0] = borrow_q;
   generate
      for (genvar i = 0; i < int'(D); i++) begin : g_fs
         digit_serial_sub_fs u_fs (
            .a    (a_sr[i]),
            .b    (b_sr[i]),
            .bin  (chain_c[i]),
            .d    (digit_c[i]),
            .bout (chain_c[i+1])
         );
      end
   endgenerate

   // New digit enters at the top; after DIGITS steps the word is in order.
   assign res_next_c = N'({digit_c, res_sr} >> D);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start is honoured in IDLE and DONE, ignored in RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt_last_c) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath-control decode.
   always_comb begin
      load_c     = 1'b0;
      step_c     = 1'b0;
      finish_c   = 1'b0;
      busy_nxt_c = (state_d == RUN);
      done_nxt_c = (state_d == DONE);
      case (state_q)
         IDLE, DONE: load_c = start;
         RUN: begin
            step_c   = 1'b1;
            finish_c = cnt_last_c;
         end
         default: ;
      endcase
   end

   // Handshake outputs, registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= busy_nxt_c;
         done <= done_nxt_c;
      end
   end

   // Operand shift registers, borrow, counter and working result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
      end else if (load_c) begin
         a_sr     <= A;
         b_sr     <= B;
         res_sr   <= '0;
         borrow_q <= Bi;
         cnt_q    <= '0;
         a_msb    <= A[N-1];
         b_msb    <= B[N-1];
      end else if (step_c) begin
         a_sr     <= a_sr >> D;
         b_sr     <= b_sr >> D;
         res_sr   <= res_next_c;
         borrow_q <= chain_c[D];
         cnt_q    <= cnt_q + CNT_W'(1);
      end
   end

   // Visible result changes only when the last digit completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Diff <= '0;
         Bo   <= 1'b0;
         ovf  <= 1'b0;
      end else if (finish_c) begin
         Diff <= res_next_c;
         Bo   <= chain_c[D];
         ovf  <= (a_msb ^ b_msb) & (a_msb ^ digit_c[D-1]);
      end
   end

endmodule
